ysyx_220066_mem_arb: RTL and testbench

Two-requester arbiter and sequencer that shares one single-ported 64-bit memory bus between the core's instruction fetch (IF) and load/store (LS) paths. It latches each granted request, drives the bus through a valid/ready request phase and an rvalid response phase, generates byte masks and lane shifts, and sign/zero-extends load data. It returns a one-cycle done pulse per request. It sits between the ysyx_220066 core and the memory/bus bridge and replaces the core's direct combinational memory access.

---
 rtl/ysyx_220066_mem_arb.sv | 179 +++++++++++++++++
 tb/tb_ysyx_220066_mem_arb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_220066_mem_arb.sv
// Round-robin arbiter/sequencer sharing one 64-bit memory bus between IF and LS.
// Latches a grant, runs REQ (valid/ready) then RESP (rvalid), returns a registered done pulse.
module ysyx_220066_mem_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [2:0]  ls_op,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  output logic [63:0] ls_rdata,
  output logic        ls_done,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        error
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state, state_d;
  logic          last_ls, cur_ls;
  logic [63:0]   r_addr;
  logic          r_wr;
  logic [2:0]    r_op;
  logic [CW-1:0] cnt;

  logic          if_elig, ls_elig, grant_if, grant_ls, grant;
  logic [63:0]   g_addr;
  logic [2:0]    g_op;
  logic          g_wr, g_mis, g_bad, timeout;
  logic [7:0]    base_mask, wmask_d;
  logic [63:0]   wdata_d, sh, ext, rdata_d;
  logic [31:0]   if_word;
  logic          fin, fin_ls, err_set;

  // A requester whose done is high this cycle is still holding its old request.
  always_comb begin
    if_elig  = if_req & ~if_done;
    ls_elig  = ls_req & ~ls_done;
    grant_if = (state == IDLE) & if_elig & (~ls_elig | last_ls);
    grant_ls = (state == IDLE) & ls_elig & (~if_elig | ~last_ls);
    grant    = grant_if | grant_ls;
    g_addr   = grant_ls ? ls_addr : if_addr;
    g_op     = grant_ls ? ls_op : 3'b110;
    g_wr     = grant_ls & ls_wr;
    case (g_op[1:0])
      2'b00:   g_mis = 1'b0;
      2'b01:   g_mis = g_addr[0];
      2'b10:   g_mis = |g_addr[1:0];
      default: g_mis = |g_addr[2:0];
    endcase
    g_bad   = (g_op == 3'b111) | g_mis;
    timeout = (cnt == CW'(TIMEOUT - 1));
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (grant && !g_bad) state_d = REQ;
      REQ: begin
        if (mem_ready)    state_d = r_wr ? IDLE : RESP;
        else if (timeout) state_d = IDLE;
      end
      RESP: if (mem_rvalid || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (g_op[1:0])
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      2'b10:   base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
    wmask_d = g_wr ? (base_mask << g_addr[2:0]) : 8'h00;
    wdata_d = g_wr ? (ls_wdata << {g_addr[2:0], 3'b000}) : 64'd0;

    sh = mem_rdata >> {r_addr[2:0], 3'b000};
    case (r_op[1:0])
      2'b00:   ext = r_op[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'b01:   ext = r_op[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'b10:   ext = r_op[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: ext = sh;
    endcase
    if_word = r_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];

    fin     = 1'b0;
    fin_ls  = cur_ls;
    err_set = 1'b0;
    rdata_d = 64'd0;
    case (state)
      IDLE: begin
        fin     = grant & g_bad;
        fin_ls  = grant_ls;
        err_set = grant & g_bad;
      end
      REQ: begin
        if (mem_ready) begin
          fin = r_wr;
        end else if (timeout) begin
          fin     = 1'b1;
          err_set = 1'b1;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          fin     = 1'b1;
          rdata_d = cur_ls ? ext : {32'd0, if_word};
        end else if (timeout) begin
          fin     = 1'b1;
          err_set = 1'b1;
        end
      end
      default: fin = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_ls   <= 1'b1;
      cur_ls    <= 1'b0;
      r_addr    <= 64'd0;
      r_wr      <= 1'b0;
      r_op      <= 3'b000;
      cnt       <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 64'd0;
      mem_wdata <= 64'd0;
      mem_wmask <= 8'd0;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;
      if_rdata  <= 32'd0;
      ls_rdata  <= 64'd0;
      error     <= 1'b0;
    end else begin
      state     <= state_d;
      mem_valid <= (state_d == REQ);
      if (grant) begin
        last_ls <= grant_ls;
        cur_ls  <= grant_ls;
        r_addr  <= g_addr;
        r_wr    <= g_wr;
        r_op    <= g_op;
        cnt     <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + CW'(1);
      end
      if (grant && !g_bad) begin
        mem_we    <= g_wr;
        mem_addr  <= {g_addr[63:3], 3'b000};
        mem_wdata <= wdata_d;
        mem_wmask <= wmask_d;
      end
      if_done <= fin & ~fin_ls;
      ls_done <= fin & fin_ls;
      if (fin && !fin_ls) if_rdata <= rdata_d[31:0];
      if (fin && fin_ls)  ls_rdata <= rdata_d;
      if (err_set) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_220066_mem_arb.sv
// Bench for ysyx_220066_mem_arb: directed vector table, multi-cycle corner sequences,
// and randomized LS traffic against a byte-level reference memory.
module tb_ysyx_220066_mem_arb;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_wr, mem_ready, mem_rvalid;
  logic [63:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [2:0]  ls_op;
  logic [31:0] if_rdata;
  logic [63:0] ls_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        if_done, ls_done, mem_valid, mem_we, error;

  always #5 clk = ~clk;

  ysyx_220066_mem_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_op(ls_op), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .error(error)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus-side memory (written from DUT outputs) and reference memory (written from spec rules)
  logic [63:0] bus_m [16];
  logic [63:0] ref_m [16];
  int          rdy_dly, rv_dly, vcnt, rv_k;
  logic        pend_rv;
  logic [63:0] rd_val;

  int          r_lat, r_vcnt, r_rvcyc;
  logic [63:0] r_rdata, r_maddr, r_wdata;
  logic [7:0]  r_mask;
  logic        r_we;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    step();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = {$urandom, $urandom};
    if (pend_rv) begin
      if (rv_k == rv_dly) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_val;
        pend_rv    = 1'b0;
      end else rv_k++;
    end
    if (mem_valid === 1'b1) begin
      if (vcnt == rdy_dly) begin
        mem_ready = 1'b1;
        vcnt      = 0;
        if (mem_we) begin
          for (int b = 0; b < 8; b++)
            if (mem_wmask[b]) bus_m[mem_addr[6:3]][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          pend_rv = 1'b1;
          rv_k    = 0;
          rd_val  = bus_m[mem_addr[6:3]];
        end
      end else vcnt++;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    pend_rv = 1'b0; vcnt = 0; rv_k = 0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic check_reset_outs();
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_ls_done", ls_done, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_error", error, 0);
  endtask

  // One LS transaction; request is raised in cycle 0, latency counted in cycles from there.
  task automatic run_ls(input logic wr, input logic [2:0] op, input logic [63:0] addr,
                        input logic [63:0] wdata);
    ls_wr = wr; ls_op = op; ls_addr = addr; ls_wdata = wdata; ls_req = 1'b1;
    r_lat = -1; r_vcnt = 0; r_rvcyc = -1; r_rdata = 64'd0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (mem_valid) begin
        if (r_vcnt == 0) begin
          r_maddr = mem_addr; r_we = mem_we; r_mask = mem_wmask; r_wdata = mem_wdata;
        end
        r_vcnt++;
      end
      if (mem_rvalid) r_rvcyc = c;
      if (ls_done) begin
        r_lat   = c;
        r_rdata = ls_rdata;
        break;
      end
    end
    ls_req = 1'b0;
    tick();
  endtask

  function automatic logic [63:0] ref_load(input logic [63:0] w, input int off, input logic [2:0] op);
    int          nb;
    logic [63:0] v, m;
    nb = 8 << op[1:0];
    v  = w >> (8 * off);
    if (nb == 64) return v;
    m = (64'd1 << nb) - 64'd1;
    v = v & m;
    if (!op[2] && v[nb-1]) v = v | ~m;
    return v;
  endfunction

  typedef struct {
    logic        wr;
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rd;
    logic [63:0] exp_data;
    logic [7:0]  exp_mask;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t tbl [12];
  int   seq [4];

  initial begin
    logic [63:0] a, wd;
    logic [2:0]  op;
    logic        wr, bad, any_bad;
    int          sz, nd, exp_lat, both, dseen;
    logic [63:0] exp_next;
    logic        exp_on;

    tbl[0]  = '{1'b0, 3'b000, 64'h8000_0005, 64'd0, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 3, 1'b0};
    tbl[1]  = '{1'b0, 3'b100, 64'h8000_0005, 64'd0, 64'h0000_8000_0000_0000, 64'h0000_0000_0000_0080, 8'h00, 3, 1'b0};
    tbl[2]  = '{1'b1, 3'b001, 64'h8000_0006, 64'h1234, 64'd0, 64'h1234_0000_0000_0000, 8'hC0, 2, 1'b0};
    tbl[3]  = '{1'b0, 3'b010, 64'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 8'h00, 3, 1'b0};
    tbl[4]  = '{1'b0, 3'b110, 64'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 8'h00, 3, 1'b0};
    tbl[5]  = '{1'b0, 3'b011, 64'h8000_0008, 64'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'h00, 3, 1'b0};
    tbl[6]  = '{1'b0, 3'b001, 64'h8000_0002, 64'd0, 64'h0000_0000_7FFF_0000, 64'h0000_0000_0000_7FFF, 8'h00, 3, 1'b0};
    tbl[7]  = '{1'b1, 3'b011, 64'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 2, 1'b0};
    tbl[8]  = '{1'b1, 3'b000, 64'h8000_0003, 64'h0000_0000_0000_00AB, 64'd0, 64'h0000_0000_AB00_0000, 8'h08, 2, 1'b0};
    tbl[9]  = '{1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 64'd0, 8'h00, 1, 1'b1};
    tbl[10] = '{1'b0, 3'b111, 64'h8000_0000, 64'd0, 64'd0, 64'd0, 8'h00, 1, 1'b1};
    tbl[11] = '{1'b0, 3'b101, 64'h8000_000E, 64'd0, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001, 8'h00, 3, 1'b1};

    if_addr = 64'd0; ls_addr = 64'd0; ls_wdata = 64'd0; ls_op = 3'b000; ls_wr = 1'b0;
    mem_rdata = 64'd0;
    for (int i = 0; i < 16; i++) bus_m[i] = {$urandom, $urandom};
    rdy_dly = 0; rv_dly = 0;
    reset_dut();
    check_reset_outs();

    // Directed vectors, zero-wait bus
    for (int i = 0; i < 12; i++) begin
      bus_m[tbl[i].addr[6:3]] = tbl[i].rd;
      rdy_dly = 0; rv_dly = 0;
      run_ls(tbl[i].wr, tbl[i].op, tbl[i].addr, tbl[i].wdata);
      chk("tbl_latency", r_lat, tbl[i].exp_lat);
      if (tbl[i].exp_lat == 1) begin
        chk("tbl_bad_no_bus", r_vcnt, 0);
        chk("tbl_bad_rdata", r_rdata, 0);
      end else begin
        chk("tbl_mem_addr", r_maddr, {tbl[i].addr[63:3], 3'b000});
        if (tbl[i].wr) begin
          chk("tbl_mem_we", r_we, 1);
          chk("tbl_wmask", r_mask, tbl[i].exp_mask);
          chk("tbl_wdata", r_wdata, tbl[i].exp_data);
        end else begin
          chk("tbl_rdata", r_rdata, tbl[i].exp_data);
        end
      end
      chk("tbl_error", error, tbl[i].exp_err);
    end

    // Wait states: ready after 3 extra cycles, rvalid 2 cycles after acceptance
    reset_dut();
    bus_m[1] = 64'hFEDC_BA98_7654_3210;
    rdy_dly = 3; rv_dly = 2;
    run_ls(1'b0, 3'b011, 64'h8000_0008, 64'd0);
    chk("wait_latency", r_lat, 8);
    chk("wait_done_after_rvalid", r_lat, r_rvcyc + 1);
    chk("wait_valid_cycles", r_vcnt, 4);
    chk("wait_rdata", r_rdata, 64'hFEDC_BA98_7654_3210);
    chk("wait_error", error, 0);

    // Timeout: ready never comes
    rdy_dly = 1000;
    run_ls(1'b0, 3'b011, 64'h8000_0008, 64'd0);
    chk("to_latency", r_lat, TO + 1);
    chk("to_valid_cycles", r_vcnt, TO);
    chk("to_rdata", r_rdata, 0);
    chk("to_error", error, 1);
    chk("to_valid_dropped", mem_valid, 0);

    // Contention from reset
    rst = 1'b1; pend_rv = 1'b0; vcnt = 0; rdy_dly = 0; rv_dly = 0;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    bus_m[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    bus_m[1] = 64'h1111_2222_3333_4444;
    if_addr = 64'h8000_0004;
    ls_addr = 64'h8000_0008; ls_op = 3'b011; ls_wr = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    step(); step();
    rst = 1'b0;
    nd = 0; both = 0; exp_on = 1'b0; exp_next = 64'd0;
    for (int c = 0; c < 60 && nd < 4; c++) begin
      tick();
      if (if_done && ls_done) both++;
      if (exp_on) begin
        chk("cont_valid_after_done", mem_valid, 1);
        chk("cont_other_granted", mem_addr, exp_next);
        exp_on = 1'b0;
      end
      if (if_done) begin
        seq[nd] = 0; nd++;
        chk("cont_if_rdata", if_rdata, 64'hAAAA_BBBB);
        exp_on = 1'b1; exp_next = 64'h8000_0008;
      end else if (ls_done) begin
        seq[nd] = 1; nd++;
        chk("cont_ls_rdata", ls_rdata, 64'h1111_2222_3333_4444);
        exp_on = 1'b1; exp_next = 64'h8000_0000;
      end
    end
    chk("cont_done_count", nd, 4);
    chk("cont_no_double_done", both, 0);
    for (int i = 0; i < nd; i++) chk("cont_order", seq[i], i % 2);
    if_req = 1'b0; ls_req = 1'b0;
    tick(); tick();

    // Reset while in RESP; the late rvalid must be ignored
    reset_dut();
    rdy_dly = 0; rv_dly = 2;
    ls_wr = 1'b0; ls_op = 3'b011; ls_addr = 64'h8000_0008; ls_req = 1'b1;
    tick(); tick();
    rst = 1'b1; ls_req = 1'b0;
    tick();
    rst = 1'b0;
    dseen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (if_done || ls_done) dseen++;
    end
    chk("midrst_no_done", dseen, 0);
    check_reset_outs();
    pend_rv = 1'b0; vcnt = 0; rv_dly = 0;
    bus_m[2] = 64'h0BAD_F00D_0000_1234;
    run_ls(1'b0, 3'b011, 64'h8000_0010, 64'd0);
    chk("midrst_next_latency", r_lat, 3);
    chk("midrst_next_rdata", r_rdata, 64'h0BAD_F00D_0000_1234);

    // Randomized LS traffic vs reference memory
    reset_dut();
    for (int i = 0; i < 16; i++) ref_m[i] = bus_m[i];
    any_bad = 1'b0;
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom % 8);
      wr = 1'($urandom % 2);
      wd = {$urandom, $urandom};
      sz = 1 << op[1:0];
      a  = 64'h8000_0000 + 64'($urandom_range(0, 127));
      if ($urandom % 4 != 0) a = a & ~64'(sz - 1);
      bad = (op == 3'b111) || (a % sz != 0);
      any_bad = any_bad | bad;
      rdy_dly = $urandom % 3;
      rv_dly  = $urandom % 3;
      exp_lat = bad ? 1 : (wr ? rdy_dly + 2 : rdy_dly + rv_dly + 3);
      run_ls(wr, op, a, wd);
      chk("rnd_latency", r_lat, exp_lat);
      if (bad) begin
        chk("rnd_bad_rdata", r_rdata, 0);
        chk("rnd_bad_no_bus", r_vcnt, 0);
      end else if (!wr) begin
        chk("rnd_load", r_rdata, ref_load(ref_m[a[6:3]], int'(a[2:0]), op));
      end else begin
        for (int b = 0; b < sz; b++)
          ref_m[a[6:3]][8*(int'(a[2:0]) + b) +: 8] = wd[8*b +: 8];
      end
    end
    chk("rnd_error_sticky", error, any_bad);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
